// File: rtl/ps2_mouse_init_seq_pkg.sv
// ps2_pkg: shared PS/2 mouse command/response constants, step-table entry
// type, error codes and sequencer state encoding.
package ps2_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Mouse-to-host response bytes
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERR      = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

    // Width of the step index into the command table
    localparam int STEP_W = 4;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_TIMEOUT = 3'd1,
        ERR_BAD_ACK = 3'd2,
        ERR_BAD_BAT = 3'd3,
        ERR_TX      = 3'd4,
        ERR_RESEND  = 3'd5
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_NEXT,
        ST_STREAM,
        ST_FAIL
    } state_e;

    // One step of the init sequence: byte to send and what follows its ACK
    typedef struct packed {
        logic [7:0] data;
        logic       expect_bat;
        logic       expect_id;
        logic       last;
    } rom_entry_t;

    // States in which the timeout counter is armed
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WAIT_TX) || (s == ST_WAIT_ACK) ||
               (s == ST_WAIT_BAT) || (s == ST_WAIT_ID);
    endfunction

endpackage

// File: rtl/ps2_mouse_init_seq_cmd_rom.sv
// ps2_cmd_rom: combinational step table for the mouse init sequence.
// With PS2_INTELLIMOUSE_EN defined, the IntelliMouse knock (F3 C8, F3 64,
// F3 50) and an F2 ID read are inserted before the final enable.
import ps2_pkg::*;

module ps2_cmd_rom #(
    parameter logic [7:0] SAMPLE_RATE = 8'h64
) (
    input  logic [STEP_W-1:0] step,
    output rom_entry_t        entry
);

    function automatic rom_entry_t mk(input logic [7:0] data, input logic bat,
                                      input logic id, input logic last);
        rom_entry_t e;
        e.data       = data;
        e.expect_bat = bat;
        e.expect_id  = id;
        e.last       = last;
        return e;
    endfunction

    // Step index to command byte and follow-up expectations
    always_comb begin
        // Unused indices fall back to the enable step so the walk always ends
        entry = mk(CMD_ENABLE, 1'b0, 1'b0, 1'b1);
        case (step)
            4'd0: entry = mk(CMD_RESET,    1'b1, 1'b0, 1'b0);
            4'd1: entry = mk(CMD_SET_RATE, 1'b0, 1'b0, 1'b0);
            4'd2: entry = mk(SAMPLE_RATE,  1'b0, 1'b0, 1'b0);
`ifdef PS2_INTELLIMOUSE_EN
            4'd3: entry = mk(CMD_SET_RATE, 1'b0, 1'b0, 1'b0);
            4'd4: entry = mk(8'hC8,        1'b0, 1'b0, 1'b0);
            4'd5: entry = mk(CMD_SET_RATE, 1'b0, 1'b0, 1'b0);
            4'd6: entry = mk(8'h64,        1'b0, 1'b0, 1'b0);
            4'd7: entry = mk(CMD_SET_RATE, 1'b0, 1'b0, 1'b0);
            4'd8: entry = mk(8'h50,        1'b0, 1'b0, 1'b0);
            4'd9: entry = mk(CMD_GET_ID,   1'b0, 1'b1, 1'b0);
            4'd10: entry = mk(CMD_ENABLE,  1'b0, 1'b0, 1'b1);
`else
            4'd3: entry = mk(CMD_ENABLE,   1'b0, 1'b0, 1'b1);
`endif
            default: entry = mk(CMD_ENABLE, 1'b0, 1'b0, 1'b1);
        endcase
    end

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// ps2_mouse_init_seq: host-side PS/2 mouse reset/configuration sequencer.
// Sends the command table from ps2_cmd_rom, checks ACK/BAT/ID responses,
// resends on FE, restarts the whole sequence on errors and timeouts, and
// enables streaming once the final enable is acknowledged.
// Optional feature macro: PS2_INTELLIMOUSE_EN (wheel detection steps).
import ps2_pkg::*;

module ps2_mouse_init_seq #(
    parameter int         ACK_TIMEOUT_CYC = 1_000_000,
    parameter int         BAT_TIMEOUT_CYC = 40_000_000,
    parameter int         MAX_RETRY       = 3,
    parameter logic [7:0] SAMPLE_RATE     = 8'h64
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic       iSTART,
    output logic [7:0] oTX_DATA,
    output logic       oTX_VALID,
    input  logic       iTX_READY,
    input  logic       iTX_DONE,
    input  logic       iTX_ERR,
    input  logic [7:0] iRX_DATA,
    input  logic       iRX_VALID,
    output logic       oSTREAM_EN,
    output logic       oBUSY,
    output logic       oERROR,
    output logic [2:0] oERR_CODE,
    output logic [2:0] oRETRY_CNT,
    output logic [7:0] oDEV_ID,
    output logic       oWHEEL
);

    localparam logic [31:0] ACK_LIM = 32'(ACK_TIMEOUT_CYC - 1);
    localparam logic [31:0] BAT_LIM = 32'(BAT_TIMEOUT_CYC - 1);
    localparam logic [2:0]  MAX_R   = 3'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [31:0]         timer_q, timer_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                stream_en_q, stream_en_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    err_code_e           err_code_q, err_code_d;
    logic [2:0]          retry_cnt_q, retry_cnt_d;
    logic [7:0]          dev_id_q, dev_id_d;
`ifdef PS2_INTELLIMOUSE_EN
    logic                wheel_q, wheel_d;
`endif

    rom_entry_t          rom;
    logic                start_ok;
    logic [31:0]         timeout_lim;
    logic                timeout_hit;
    logic                retry_req;
    err_code_e           retry_code;
    logic                resend_req;

    ps2_cmd_rom #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_rom (
        .step  (step_q),
        .entry (rom)
    );

    // Restart is only honoured when no sequence is running
    assign start_ok = iSTART &&
                      ((state_q == ST_IDLE) || (state_q == ST_STREAM) || (state_q == ST_FAIL));

    // Per-state timeout limit; BAT can take far longer than a plain ACK
    always_comb begin
        timeout_lim = ACK_LIM;
        if ((state_q == ST_WAIT_BAT) || (state_q == ST_WAIT_ID)) begin
            timeout_lim = BAT_LIM;
        end
    end

    assign timeout_hit = (timer_q == timeout_lim);

    // Sequencer next-state, command output and retry bookkeeping
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        err_code_d  = err_code_q;
        retry_cnt_d = retry_cnt_q;
        dev_id_d    = dev_id_q;
`ifdef PS2_INTELLIMOUSE_EN
        wheel_d     = wheel_q;
`endif
        retry_req   = 1'b0;
        retry_code  = ERR_NONE;
        resend_req  = 1'b0;

        case (state_q)
            ST_IDLE, ST_STREAM, ST_FAIL: begin
                if (start_ok) begin
                    err_code_d  = ERR_NONE;
                    retry_cnt_d = '0;
                    step_d      = '0;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                // Raise valid one cycle after entry; data held until accepted
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = rom.data;
                end else if (iTX_READY) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT_TX;
                end
            end

            ST_WAIT_TX: begin
                // A coincident error pulse takes precedence over done
                if (iTX_ERR) begin
                    retry_req  = 1'b1;
                    retry_code = ERR_TX;
                end else if (iTX_DONE) begin
                    state_d = ST_WAIT_ACK;
                end else if (timeout_hit) begin
                    retry_req  = 1'b1;
                    retry_code = ERR_TIMEOUT;
                end
            end

            ST_WAIT_ACK: begin
                if (iRX_VALID) begin
                    if (iRX_DATA == RSP_ACK) begin
                        if (rom.expect_bat) begin
                            state_d = ST_WAIT_BAT;
                        end else if (rom.expect_id) begin
                            state_d = ST_WAIT_ID;
                        end else if (rom.last) begin
                            state_d = ST_STREAM;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if (iRX_DATA == RSP_RESEND) begin
                        resend_req = 1'b1;
                    end else begin
                        retry_req  = 1'b1;
                        retry_code = ERR_BAD_ACK;
                    end
                end else if (timeout_hit) begin
                    retry_req  = 1'b1;
                    retry_code = ERR_TIMEOUT;
                end
            end

            ST_WAIT_BAT: begin
                if (iRX_VALID) begin
                    if (iRX_DATA == RSP_BAT_OK) begin
                        state_d = ST_WAIT_ID;
                    end else begin
                        retry_req  = 1'b1;
                        retry_code = ERR_BAD_BAT;
                    end
                end else if (timeout_hit) begin
                    retry_req  = 1'b1;
                    retry_code = ERR_TIMEOUT;
                end
            end

            ST_WAIT_ID: begin
                if (iRX_VALID) begin
                    dev_id_d = iRX_DATA;
`ifdef PS2_INTELLIMOUSE_EN
                    wheel_d  = (iRX_DATA == 8'h03);
`endif
                    state_d  = rom.last ? ST_STREAM : ST_NEXT;
                end else if (timeout_hit) begin
                    retry_req  = 1'b1;
                    retry_code = ERR_TIMEOUT;
                end
            end

            ST_NEXT: begin
                step_d  = step_q + 4'd1;
                state_d = ST_SEND;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FE: resend the same step, consuming one retry
        if (resend_req) begin
            if (retry_cnt_q == MAX_R) begin
                err_code_d = ERR_RESEND;
                state_d    = ST_FAIL;
            end else begin
                retry_cnt_d = retry_cnt_q + 3'd1;
                state_d     = ST_SEND;
            end
        end

        // Any other failure restarts from the reset command
        if (retry_req) begin
            err_code_d = retry_code;
            if (retry_cnt_q == MAX_R) begin
                state_d = ST_FAIL;
            end else begin
                retry_cnt_d = retry_cnt_q + 3'd1;
                step_d      = '0;
                state_d     = ST_SEND;
            end
        end
    end

    // Timeout counter restarts whenever a wait state is (re)entered
    always_comb begin
        timer_d = timer_q + 32'd1;
        if ((state_d != state_q) || !is_wait_state(state_d)) begin
            timer_d = '0;
        end
    end

    // Status flags follow the registered state, one cycle behind it
    always_comb begin
        busy_d      = (state_q == ST_SEND) || (state_q == ST_NEXT) || is_wait_state(state_q);
        stream_en_d = (state_q == ST_STREAM) && !start_ok;
        error_d     = start_ok ? 1'b0 : (error_q || (state_q == ST_FAIL));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            timer_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            stream_en_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            retry_cnt_q <= '0;
            dev_id_q    <= 8'h00;
`ifdef PS2_INTELLIMOUSE_EN
            wheel_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            stream_en_q <= stream_en_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            retry_cnt_q <= retry_cnt_d;
            dev_id_q    <= dev_id_d;
`ifdef PS2_INTELLIMOUSE_EN
            wheel_q     <= wheel_d;
`endif
        end
    end

    assign oTX_DATA   = tx_data_q;
    assign oTX_VALID  = tx_valid_q;
    assign oSTREAM_EN = stream_en_q;
    assign oBUSY      = busy_q;
    assign oERROR     = error_q;
    assign oERR_CODE  = err_code_q;
    assign oRETRY_CNT = retry_cnt_q;
    assign oDEV_ID    = dev_id_q;
`ifdef PS2_INTELLIMOUSE_EN
    assign oWHEEL     = wheel_q;
`else
    assign oWHEEL     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Testbench for ps2_mouse_init_seq: a transceiver/mouse model answers each
// transmitted command; a monitor checks every transmitted byte against a
// queue of expected bytes pushed by the directed tests.
`timescale 1ns/1ps

module tb_ps2_mouse_init_seq;

    logic       iCLK_50 = 1'b0;
    logic       iRST_n;
    logic       iSTART;
    logic [7:0] oTX_DATA;
    logic       oTX_VALID;
    logic       iTX_READY;
    logic       iTX_DONE;
    logic       iTX_ERR;
    logic [7:0] iRX_DATA;
    logic       iRX_VALID;
    logic       oSTREAM_EN;
    logic       oBUSY;
    logic       oERROR;
    logic [2:0] oERR_CODE;
    logic [2:0] oRETRY_CNT;
    logic [7:0] oDEV_ID;
    logic       oWHEEL;

`ifdef PS2_INTELLIMOUSE_EN
    localparam logic [7:0] EXP_ID    = 8'h03;
    localparam logic       EXP_WHEEL = 1'b1;
`else
    localparam logic [7:0] EXP_ID    = 8'h00;
    localparam logic       EXP_WHEEL = 1'b0;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] exp_q[$];

    // Mouse model behaviour knobs, set by the directed tests
    bit silent        = 1'b0;
    int fe_left       = 0;
    int bat_fail_left = 0;

    ps2_mouse_init_seq #(
        .ACK_TIMEOUT_CYC (40),
        .BAT_TIMEOUT_CYC (80),
        .MAX_RETRY       (3),
        .SAMPLE_RATE     (8'h64)
    ) dut (
        .iCLK_50    (iCLK_50),
        .iRST_n     (iRST_n),
        .iSTART     (iSTART),
        .oTX_DATA   (oTX_DATA),
        .oTX_VALID  (oTX_VALID),
        .iTX_READY  (iTX_READY),
        .iTX_DONE   (iTX_DONE),
        .iTX_ERR    (iTX_ERR),
        .iRX_DATA   (iRX_DATA),
        .iRX_VALID  (iRX_VALID),
        .oSTREAM_EN (oSTREAM_EN),
        .oBUSY      (oBUSY),
        .oERROR     (oERROR),
        .oERR_CODE  (oERR_CODE),
        .oRETRY_CNT (oRETRY_CNT),
        .oDEV_ID    (oDEV_ID),
        .oWHEEL     (oWHEEL)
    );

    always #10 iCLK_50 = ~iCLK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected bytes after an FF that succeeded
    task automatic push_cfg_tail();
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h64);
`ifdef PS2_INTELLIMOUSE_EN
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hC8);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h64);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'hF2);
`endif
        exp_q.push_back(8'hF4);
    endtask

    task automatic pulse_start();
        iSTART = 1'b1;
        @(negedge iCLK_50);
        iSTART = 1'b0;
    endtask

    // Wait (bounded) until the sequencer settles in STREAM or FAIL
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!((oSTREAM_EN || oERROR) && !oBUSY) && (n < 3000)) begin
            @(negedge iCLK_50);
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    // Transmit monitor: one line per accepted command byte
    initial begin : tx_monitor
        logic [7:0] e;
        forever begin
            @(negedge iCLK_50);
            if (iRST_n && oTX_VALID && iTX_READY) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL tx_unexpected: got %02h, required no byte", oTX_DATA);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx byte %02h (expected %02h)", oTX_DATA, e);
                    chk("tx_byte", 32'(oTX_DATA), 32'(e));
                end
            end
        end
    end

    // Transceiver + mouse model
    initial begin : device_model
        logic [7:0] b;
        logic [7:0] rsp [4];
        int nrsp;
        iTX_DONE  = 1'b0;
        iTX_ERR   = 1'b0;
        iRX_DATA  = 8'h00;
        iRX_VALID = 1'b0;
        forever begin
            @(negedge iCLK_50);
            if (iRST_n && oTX_VALID && iTX_READY) begin
                b = oTX_DATA;
                repeat (2) @(negedge iCLK_50);
                iTX_DONE = 1'b1;
                @(negedge iCLK_50);
                iTX_DONE = 1'b0;
                nrsp = 0;
                if (!silent) begin
                    if (b == 8'hFF) begin
                        rsp[0] = 8'hFA;
                        if (bat_fail_left > 0) begin
                            rsp[1] = 8'hFC;
                            nrsp = 2;
                            bat_fail_left--;
                        end else begin
                            rsp[1] = 8'hAA;
                            rsp[2] = 8'h00;
                            nrsp = 3;
                        end
                    end else if ((b == 8'hF3) && (fe_left > 0)) begin
                        rsp[0] = 8'hFE;
                        nrsp = 1;
                        fe_left--;
                    end else if (b == 8'hF2) begin
                        rsp[0] = 8'hFA;
                        rsp[1] = 8'h03;
                        nrsp = 2;
                    end else begin
                        rsp[0] = 8'hFA;
                        nrsp = 1;
                    end
                end
                for (int i = 0; i < nrsp; i++) begin
                    repeat (2) @(negedge iCLK_50);
                    iRX_DATA  = rsp[i];
                    iRX_VALID = 1'b1;
                    @(negedge iCLK_50);
                    iRX_VALID = 1'b0;
                end
            end
        end
    end

    // Global time bound
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time bound");
        $fatal(1, "time bound exceeded");
    end

    initial begin : stimulus
        iRST_n    = 1'b0;
        iSTART    = 1'b0;
        iTX_READY = 1'b1;
        repeat (3) @(negedge iCLK_50);

        // Reset values
        chk("rst_tx_data",   32'(oTX_DATA),   32'h00);
        chk("rst_tx_valid",  32'(oTX_VALID),  32'd0);
        chk("rst_stream_en", 32'(oSTREAM_EN), 32'd0);
        chk("rst_busy",      32'(oBUSY),      32'd0);
        chk("rst_error",     32'(oERROR),     32'd0);
        chk("rst_retry",     32'(oRETRY_CNT), 32'd0);
        iRST_n = 1'b1;
        @(negedge iCLK_50);

        // Test 1: every command acknowledged
        exp_q.push_back(8'hFF);
        push_cfg_tail();
        pulse_start();
        chk("start_valid_n",  32'(oTX_VALID), 32'd0);
        @(negedge iCLK_50);
        chk("start_busy_n1",  32'(oBUSY),     32'd1);
        chk("start_valid_n1", 32'(oTX_VALID), 32'd1);
        chk("start_data_n1",  32'(oTX_DATA),  32'hFF);
        wait_done("t1_done");
        chk("t1_stream_en", 32'(oSTREAM_EN), 32'd1);
        chk("t1_error",     32'(oERROR),     32'd0);
        chk("t1_retry",     32'(oRETRY_CNT), 32'd0);
        chk("t1_dev_id",    32'(oDEV_ID),    32'(EXP_ID));
        chk("t1_wheel",     32'(oWHEEL),     32'(EXP_WHEEL));
        repeat (4) @(negedge iCLK_50);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 2: FE once on F3 resends F3; a start while busy is ignored
        fe_left = 1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF3);
        push_cfg_tail();
        pulse_start();
        repeat (20) @(negedge iCLK_50);
        pulse_start();
        wait_done("t2_done");
        chk("t2_stream_en", 32'(oSTREAM_EN), 32'd1);
        chk("t2_retry",     32'(oRETRY_CNT), 32'd1);
        chk("t2_err_code",  32'(oERR_CODE),  32'd0);
        repeat (4) @(negedge iCLK_50);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: silent mouse -> four FF attempts then FAIL with timeout
        silent = 1'b1;
        repeat (4) exp_q.push_back(8'hFF);
        pulse_start();
        wait_done("t3_done");
        chk("t3_error",     32'(oERROR),     32'd1);
        chk("t3_err_code",  32'(oERR_CODE),  32'd1);
        chk("t3_busy",      32'(oBUSY),      32'd0);
        chk("t3_retry",     32'(oRETRY_CNT), 32'd3);
        chk("t3_stream_en", 32'(oSTREAM_EN), 32'd0);
        repeat (60) @(negedge iCLK_50);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 4: BAT answered with FC once, second attempt succeeds
        silent = 1'b0;
        bat_fail_left = 1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        push_cfg_tail();
        pulse_start();
        wait_done("t4_done");
        chk("t4_stream_en", 32'(oSTREAM_EN), 32'd1);
        chk("t4_error",     32'(oERROR),     32'd0);
        chk("t4_err_code",  32'(oERR_CODE),  32'd3);
        chk("t4_retry",     32'(oRETRY_CNT), 32'd1);
        repeat (4) @(negedge iCLK_50);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: reset while waiting for ACK, then a clean restart
        silent = 1'b1;
        exp_q.push_back(8'hFF);
        pulse_start();
        repeat (12) @(negedge iCLK_50);
        chk("t5_busy_before_rst", 32'(oBUSY), 32'd1);
        iRST_n = 1'b0;
        @(negedge iCLK_50);
        chk("t5_rst_tx_data",   32'(oTX_DATA),   32'h00);
        chk("t5_rst_tx_valid",  32'(oTX_VALID),  32'd0);
        chk("t5_rst_busy",      32'(oBUSY),      32'd0);
        chk("t5_rst_stream_en", 32'(oSTREAM_EN), 32'd0);
        chk("t5_rst_err_code",  32'(oERR_CODE),  32'd0);
        chk("t5_rst_dev_id",    32'(oDEV_ID),    32'h00);
        chk("t5_rst_wheel",     32'(oWHEEL),     32'd0);
        iRST_n = 1'b1;
        silent = 1'b0;
        @(negedge iCLK_50);
        exp_q.push_back(8'hFF);
        push_cfg_tail();
        pulse_start();
        wait_done("t5_done");
        chk("t5_stream_en", 32'(oSTREAM_EN), 32'd1);
        chk("t5_retry",     32'(oRETRY_CNT), 32'd0);
        chk("t5_dev_id",    32'(oDEV_ID),    32'(EXP_ID));
        repeat (4) @(negedge iCLK_50);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init_seq.md
# ps2_mouse_init_seq

Host-side command sequencer for the PS/2 mouse port. It sits between the byte-level PS/2 transceiver (host-to-device send and device-to-host receive) and the mouse packet decoder. It issues the reset and configuration command sequence, checks every device response and retries on failure. It asserts `oSTREAM_EN` once the mouse is in streaming mode, which gates received bytes into the packet decoder.

## Interface
Parameters:
- `ACK_TIMEOUT_CYC`, default 1_000_000 — cycles to wait for ACK (`0xFA`) after a byte is sent; 20 ms at 50 MHz.
- `BAT_TIMEOUT_CYC`, default 40_000_000 — cycles to wait for each BAT byte; 800 ms.
- `MAX_RETRY`, default 3 — number of retries allowed before entering FAIL.
- `SAMPLE_RATE`, default 8'h64 — sample rate value sent after `0xF3`.

Ports:
- `iCLK_50` in 1 — system clock.
- `iRST_n` in 1 — reset; synchronous, active-low.
- `iSTART` in 1 — single-cycle start/restart pulse.
- `oTX_DATA` out 8 — command byte to transceiver.
- `oTX_VALID` out 1 — command byte valid.
- `iTX_READY` in 1 — transceiver accepts the byte.
- `iTX_DONE` in 1 — one-cycle pulse; byte shifted out and device line-ACK seen.
- `iTX_ERR` in 1 — one-cycle pulse; transmit failed (no line-ACK or clock timeout).
- `iRX_DATA` in 8 — received byte.
- `iRX_VALID` in 1 — one-cycle pulse; `iRX_DATA` valid.
- `oSTREAM_EN` out 1 — init complete; decoder may consume RX bytes.
- `oBUSY` out 1 — sequence in progress.
- `oERROR` out 1 — sticky failure flag.
- `oERR_CODE` out 3 — last error code.
- `oRETRY_CNT` out 3 — retries consumed.
- `oDEV_ID` out 8 — device ID byte captured after BAT.
- `oWHEEL` out 1 — wheel mouse detected.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, NEXT, STREAM, FAIL.
- Base sequence (step index into command ROM):
  - `FF` → ACK, then BAT `AA`, then ID.
  - `F3` → ACK; `SAMPLE_RATE` → ACK.
  - `F4` → ACK.
  - Then STREAM.
- Transitions:
  - IDLE → SEND on `iSTART`.
  - SEND: drive `oTX_VALID`/`oTX_DATA`; → WAIT_TX on handshake.
  - WAIT_TX → WAIT_ACK on `iTX_DONE`.
- Responses in WAIT_ACK:
  - `FA` → NEXT, or WAIT_BAT after `FF`.
  - `FE` → resend the same byte (SEND); counts one retry.
  - `FC` or any other byte → error code 2; full retry.
- BAT and ID checks:
  - WAIT_BAT: `AA` → WAIT_ID; any other byte → code 3; full retry.
  - WAIT_ID: capture any byte into `oDEV_ID`.
- Errors:
  - Timeout in any wait state → code 1.
  - `iTX_ERR` → code 4.
- Full retry: increment `oRETRY_CNT`, restart at step 0 (`FF`).
- FAIL entry: when a retry is needed and `oRETRY_CNT == MAX_RETRY`. Resend-induced entry uses code 5. FAIL sets `oERROR`, clears `oBUSY`, and holds.
- `iSTART` in IDLE, STREAM or FAIL:
  - clears `oERROR`, `oERR_CODE`, `oRETRY_CNT`, `oSTREAM_EN`;
  - restarts at step 0.
- `iSTART` is ignored while `oBUSY`.
- STREAM: `oSTREAM_EN=1`, `oBUSY=0`. RX bytes are not consumed by this block.
- RX bytes arriving in IDLE, SEND or WAIT_TX are dropped.

## Timing
- All outputs are registered. Reset values: `oTX_DATA=00`, `oTX_VALID=0`, `oSTREAM_EN=0`, `oBUSY=0`, `oERROR=0`, `oERR_CODE=0`, `oRETRY_CNT=0`, `oDEV_ID=00`, `oWHEEL=0`. State is IDLE.
- `iRST_n` low at any edge, including mid-transfer, forces the reset values on that edge. The transceiver must be reset by the same signal.
- `iSTART` at edge N → `oBUSY=1`, `oTX_VALID=1`, `oTX_DATA=FF` after edge N+1.
- Handshake: a transfer occurs when `oTX_VALID && iTX_READY` at a clock edge. `oTX_VALID` drops on the following edge. `oTX_DATA` is stable while `oTX_VALID=1`.
- Timeout counter:
  - clears on entry to each wait state;
  - expires when it reaches the parameter value minus 1;
  - WAIT_ACK uses `ACK_TIMEOUT_CYC`; WAIT_BAT and WAIT_ID use `BAT_TIMEOUT_CYC`.
- If `iRX_VALID` and timeout expiry coincide, RX wins.
- If `iTX_DONE` and `iTX_ERR` coincide, ERR wins.
- Final `FA` (for `F4`) at edge N → `oSTREAM_EN=1` after edge N+1.

## Configuration
- `PS2_INTELLIMOUSE_EN` defined:
  - after `F4`'s predecessor step (sample rate), insert `F3 C8`, `F3 64`, `F3 50`, then `F2` → ACK → ID byte;
  - the ID byte updates `oDEV_ID`;
  - `oWHEEL=1` if ID == `03`.
- `PS2_INTELLIMOUSE_EN` undefined: steps absent, `oWHEEL` tied 0.

## Structure
- Package `ps2_pkg`:
  - command constants (`CMD_RESET=FF`, `CMD_SET_RATE=F3`, `CMD_GET_ID=F2`, `CMD_ENABLE=F4`);
  - response constants (`RSP_ACK=FA`, `RSP_RESEND=FE`, `RSP_ERR=FC`, `RSP_BAT_OK=AA`);
  - error-code enum;
  - state enum.
- Sub-module `ps2_cmd_rom`: combinational map from step index to {byte, expect-BAT, expect-ID, last} flags. It holds the macro-dependent step table.

## Test plan
- Model answers every command with `FA`, plus `AA 00` after `FF` → TX bytes `FF F3 64 F4`; `oSTREAM_EN=1`; `oRETRY_CNT=0`; `oDEV_ID=00`.
- Model answers `FE` once to `F3` → `F3` resent; `oRETRY_CNT=1`; sequence completes.
- No response after `FF`, `MAX_RETRY=3` → four `FF` attempts, then `oERROR=1`, `oERR_CODE=1`, `oBUSY=0`.
- BAT returns `FC` → `oERR_CODE=3`, restart from `FF`; second attempt succeeds → `oSTREAM_EN=1`, `oERROR=0`.
- `iRST_n` low during WAIT_ACK → all outputs at reset values the next edge; `iSTART` later → `FF` sent cleanly.
- With `PS2_INTELLIMOUSE_EN`, model returns ID `03` → `oWHEEL=1`, `oDEV_ID=03`.
